// File: rtl/inv_sub_bytes.sv
`default_nettype none
// ============================================================================
// Module   : inv_sub_bytes
// Purpose  : AES InvSubBytes; all 16 state bytes through the inverse S-box,
//            one registered pass, one state per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module inv_sub_bytes (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [127:0] message,
    output logic         out_valid,
    output logic [127:0] Dmessage
);

    // Inverse S-box as a constant ROM; entry n is InvSbox(n).
    localparam logic [7:0] c_INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    logic [127:0] w_sub;
    logic [127:0] r_dmessage;
    logic         r_out_valid;

    // Substitution is position-preserving, so slice index equals byte lane.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_byte
            assign w_sub[gi*8 +: 8] = c_INV_SBOX[message[gi*8 +: 8]];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dmessage  <= 128'h0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_dmessage <= w_sub;
            end
        end
    end

    assign Dmessage  = r_dmessage;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_inv_sub_bytes.sv
`default_nettype none
// Scoreboard bench for inv_sub_bytes: stimulus pushes expected results,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_inv_sub_bytes;

    localparam logic [7:0] c_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Forward S-box, used to confirm Sbox(result byte) returns the input byte.
    localparam logic [7:0] c_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef struct packed {
        logic [127:0] exp;
        logic [127:0] src;
    } item_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b1;
    logic [127:0] message = {16{8'hff}};
    logic         out_valid;
    logic [127:0] Dmessage;

    item_t        sb_q[$];
    int           checks = 0;
    int           failures = 0;
    logic         prev_rst_n = 1'b0;
    logic [127:0] last_out = 128'h0;

    inv_sub_bytes dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .message   (message),
        .out_valid (out_valid),
        .Dmessage  (Dmessage)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs; expected result queued only if it will be captured.
    task automatic drive(input logic v, input logic [127:0] m, input logic r, input logic [127:0] e);
        item_t it;
        @(posedge clk);
        #2;
        in_valid = v;
        message  = m;
        rst_n    = r;
        if (r && v) begin
            it.exp = e;
            it.src = m;
            sb_q.push_back(it);
        end
    endtask

    function automatic logic [127:0] model_inv(input logic [127:0] m);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[b*8 +: 8] = c_INV[m[b*8 +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] model_fwd(input logic [127:0] m);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[b*8 +: 8] = c_FWD[m[b*8 +: 8]];
        return r;
    endfunction

    // Monitor: prev_rst_n is the reset value sampled at the edge just passed.
    always @(negedge clk) begin
        item_t it;
        if (!prev_rst_n) begin
            chk("reset_valid", {127'h0, out_valid}, 128'h0);
            chk("reset_data", Dmessage, 128'h0);
            last_out = 128'h0;
        end else if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out_valid", {127'h0, out_valid}, 128'h0);
            end else begin
                it = sb_q.pop_front();
                chk("data", Dmessage, it.exp);
                chk("fwd_roundtrip", model_fwd(Dmessage), it.src);
                last_out = it.exp;
            end
        end else begin
            chk("idle_valid", {127'h0, out_valid}, 128'h0);
            chk("hold_data", Dmessage, last_out);
        end
        prev_rst_n = rst_n;
    end

    initial begin
        logic [127:0] v;
        logic [127:0] e;

        // Reset held with live inputs.
        drive(1'b1, {16{8'hff}}, 1'b0, 128'h0);
        drive(1'b1, {16{8'hff}}, 1'b0, 128'h0);

        // Known vector, then an idle cycle to check hold.
        drive(1'b1, 128'h7c266e85a762bddf7c266e85a762bddf, 1'b1,
              128'h0123456789abcdef0123456789abcdef);
        drive(1'b0, 128'h0, 1'b1, 128'h0);
        drive(1'b0, 128'h0, 1'b1, 128'h0);

        // Corner values back-to-back.
        drive(1'b1, {16{8'h63}}, 1'b1, {16{8'h00}});
        drive(1'b1, {16{8'h00}}, 1'b1, {16{8'h52}});
        drive(1'b1, {16{8'hff}}, 1'b1, {16{8'h7d}});
        drive(1'b0, 128'h0, 1'b1, 128'h0);

        // Full table sweep: vector k carries bytes 16k..16k+15, byte 0 in the MSBs.
        for (int k = 0; k < 16; k++) begin
            for (int b = 0; b < 16; b++) v[127 - b*8 -: 8] = 8'(k*16 + b);
            e = model_inv(v);
            drive(1'b1, v, 1'b1, e);
        end
        drive(1'b0, 128'h0, 1'b1, 128'h0);

        // Reset asserted on the same edge as a valid vector.
        drive(1'b1, 128'h7c266e85a762bddf7c266e85a762bddf, 1'b0, 128'h0);
        drive(1'b0, 128'h0, 1'b1, 128'h0);
        drive(1'b0, 128'h0, 1'b1, 128'h0);

        // Load a value, then toggle message with in_valid low.
        drive(1'b1, {16{8'h16}}, 1'b1, {16{8'hff}});
        for (int i = 0; i < 8; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            drive(1'b0, v, 1'b1, 128'h0);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 128'(sb_q.size()), 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
